atm_session_ctrl: RTL and testbench

ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

---
 rtl/atm_pkg.sv | 18 +
 rtl/atm_timeout_cnt.sv | 18 +
 rtl/atm_session_ctrl.sv | 176 +++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// atm_pkg: shared FSM state encoding, op codes and error codes for the ATM session controller
package atm_pkg;
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] LOAD     = 3'd1;
   localparam logic [2:0] PSW_WAIT = 3'd2;
   localparam logic [2:0] MENU     = 3'd3;
   localparam logic [2:0] EXEC     = 3'd4;
   localparam logic [2:0] WRITE    = 3'd5;
   localparam logic [2:0] EJECT    = 3'd6;
   localparam logic [1:0] OP_BAL   = 2'd0;
   localparam logic [1:0] OP_WD    = 2'd1;
   localparam logic [1:0] OP_DEP   = 2'd2;
   localparam logic [1:0] OP_EXIT  = 2'd3;
   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_PSW   = 2'd1;
   localparam logic [1:0] ERR_FUNDS = 2'd2;
   localparam logic [1:0] ERR_OVF   = 2'd3;
endpackage

// File: rtl/atm_timeout_cnt.sv
// atm_timeout_cnt: idle cycle counter that raises expired after limit enabled cycles without a clear
module atm_timeout_cnt #(
   parameter int limit = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int w = $clog2(limit + 1);
   logic [w-1:0] cnt;
   assign expired = cnt == w'(limit);
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (clear || !enable) cnt <= '0;
      else if (!expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: card/PIN session FSM with account read/write handshakes, lockout and idle timeout
module atm_session_ctrl
   import atm_pkg::*;
#(
   parameter int card_width     = 6,
   parameter int password_width = 16,
   parameter int balance_width  = 20,
   parameter int users_num      = 10,
   parameter int max_tries      = 3,
   parameter int timeout_cycles = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      card_in,
   input  logic [card_width-1:0]     card_number,
   input  logic                      psw_valid,
   input  logic [password_width-1:0] password_input,
   input  logic                      op_req,
   input  logic [1:0]                op_code,
   input  logic [balance_width-1:0]  amount,
   output logic [card_width-1:0]     acct_sel,
   output logic                      acct_rd,
   input  logic                      acct_rd_ack,
   input  logic [password_width-1:0] acct_password,
   input  logic [balance_width-1:0]  acct_balance,
   output logic                      acct_wr,
   output logic [balance_width-1:0]  acct_wr_data,
   input  logic                      acct_wr_ack,
   output logic [balance_width-1:0]  balance,
   output logic                      op_done,
   output logic                      op_err,
   output logic [1:0]                err_code,
   output logic                      card_eject,
   output logic                      busy,
   output logic                      locked
);
   localparam int tw = $clog2(max_tries + 1);
   logic [2:0]                state, prev_state;
   logic [tw-1:0]             tries;
   logic [users_num-1:0]      lock_map;
   logic [password_width-1:0] psw_q;
   logic [balance_width-1:0]  cap_bal, amt_q, new_bal;
   logic [1:0]                op_q;
   logic [balance_width:0]    sum;
   logic                      expired, card_locked;
   assign busy         = state != IDLE;
   assign acct_wr_data = new_bal;
   assign sum          = {1'b0, balance} + {1'b0, amt_q};
   assign card_locked  = |(lock_map & (users_num'(1) << card_number));
   // state != prev_state restarts the idle count on every state entry
   atm_timeout_cnt #(.limit(timeout_cycles)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clear   (psw_valid || op_req || state != prev_state),
      .enable  (state == PSW_WAIT || state == MENU),
      .expired (expired)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state      <= IDLE;
         prev_state <= IDLE;
         tries      <= '0;
         lock_map   <= '0;
         psw_q      <= '0;
         cap_bal    <= '0;
         amt_q      <= '0;
         new_bal    <= '0;
         op_q       <= OP_BAL;
         acct_sel   <= '0;
         acct_rd    <= 1'b0;
         acct_wr    <= 1'b0;
         balance    <= '0;
         op_done    <= 1'b0;
         op_err     <= 1'b0;
         err_code   <= ERR_NONE;
         card_eject <= 1'b0;
         locked     <= 1'b0;
      end else begin
         prev_state <= state;
         acct_rd    <= 1'b0;
         acct_wr    <= 1'b0;
         op_done    <= 1'b0;
         op_err     <= 1'b0;
         card_eject <= 1'b0;
         locked     <= 1'b0;
         case (state)
            IDLE:
               if (card_in) begin
                  if (card_number >= card_width'(users_num)) begin
                     op_err     <= 1'b1;
                     err_code   <= ERR_OVF;
                     card_eject <= 1'b1;
                  end else if (card_locked) begin
                     locked     <= 1'b1;
                     card_eject <= 1'b1;
                  end else begin
                     acct_sel <= card_number;
                     tries    <= '0;
                     acct_rd  <= 1'b1;
                     state    <= LOAD;
                  end
               end
            LOAD:
               if (acct_rd_ack) begin
                  psw_q   <= acct_password;
                  cap_bal <= acct_balance;
                  state   <= PSW_WAIT;
               end
            PSW_WAIT:
               if (psw_valid) begin
                  if (password_input == psw_q) begin
                     balance <= cap_bal;
                     state   <= MENU;
                  end else begin
                     tries    <= tries + 1'b1;
                     op_err   <= 1'b1;
                     err_code <= ERR_PSW;
                     if (tries == tw'(max_tries - 1)) begin
                        lock_map   <= lock_map | (users_num'(1) << acct_sel);
                        card_eject <= 1'b1;
                        state      <= EJECT;
                     end
                  end
               end else if (expired) begin
                  card_eject <= 1'b1;
                  state      <= EJECT;
               end
            MENU:
               if (op_req) begin
                  op_q       <= op_code;
                  amt_q      <= amount;
                  card_eject <= op_code == OP_EXIT;
                  state      <= op_code == OP_EXIT ? EJECT : EXEC;
               end else if (expired) begin
                  card_eject <= 1'b1;
                  state      <= EJECT;
               end
            EXEC: begin
               state <= MENU;
               case (op_q)
                  OP_BAL: op_done <= 1'b1;
                  OP_WD:
                     if (amt_q > balance) begin
                        op_err   <= 1'b1;
                        err_code <= ERR_FUNDS;
                     end else begin
                        new_bal <= balance - amt_q;
                        acct_wr <= 1'b1;
                        state   <= WRITE;
                     end
                  OP_DEP:
                     if (sum[balance_width]) begin
                        op_err   <= 1'b1;
                        err_code <= ERR_OVF;
                     end else begin
                        new_bal <= sum[balance_width-1:0];
                        acct_wr <= 1'b1;
                        state   <= WRITE;
                     end
                  default: state <= MENU;
               endcase
            end
            WRITE:
               if (acct_wr_ack) begin
                  balance <= new_bal;
                  op_done <= 1'b1;
                  state   <= MENU;
               end
            EJECT: begin
               balance <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed session scenarios with an expected-event queue checked by a monitor
module tb_atm_session_ctrl;
   localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3, K_LOCK = 4, K_EJ = 5;
   typedef struct {int kind; int data;} ev_t;
   logic        clk = 0, rst = 0;
   logic        card_in = 0, psw_valid = 0, op_req = 0;
   logic [5:0]  card_number = 0;
   logic [15:0] password_input = 0;
   logic [1:0]  op_code = 0;
   logic [19:0] amount = 0;
   logic [5:0]  acct_sel;
   logic        acct_rd, acct_rd_ack = 0, acct_wr, acct_wr_ack = 0;
   logic [15:0] acct_password = 0;
   logic [19:0] acct_balance = 0, acct_wr_data, balance;
   logic        op_done, op_err, card_eject, busy, locked;
   logic [1:0]  err_code;
   logic [15:0] pw [16];
   logic [19:0] bal [16];
   logic        hold_wr = 0;
   ev_t         q[$];
   int          checks = 0, passed = 0;

   atm_session_ctrl dut (
      .clk(clk), .rst(rst), .card_in(card_in), .card_number(card_number),
      .psw_valid(psw_valid), .password_input(password_input), .op_req(op_req),
      .op_code(op_code), .amount(amount), .acct_sel(acct_sel), .acct_rd(acct_rd),
      .acct_rd_ack(acct_rd_ack), .acct_password(acct_password), .acct_balance(acct_balance),
      .acct_wr(acct_wr), .acct_wr_data(acct_wr_data), .acct_wr_ack(acct_wr_ack),
      .balance(balance), .op_done(op_done), .op_err(op_err), .err_code(err_code),
      .card_eject(card_eject), .busy(busy), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic push(input int kind, input int data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      q.push_back(e);
   endtask

   task automatic pop_cmp(input int kind, input int data);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         $display("FAIL event: unexpected kind %0d data %0d, nothing expected", kind, data);
         return;
      end
      e = q.pop_front();
      if (e.kind == kind && e.data == data) passed++;
      else $display("FAIL event: got kind %0d data %0d expected kind %0d data %0d", kind, data, e.kind, e.data);
   endtask

   // monitor: fixed per-cycle order rd, wr, done, err, locked, eject
   always @(negedge clk)
      if (rst) begin
         if (acct_rd) pop_cmp(K_RD, int'(acct_sel));
         if (acct_wr) pop_cmp(K_WR, int'(acct_wr_data));
         if (op_done) pop_cmp(K_DONE, int'(balance));
         if (op_err) pop_cmp(K_ERR, int'(err_code));
         if (locked) pop_cmp(K_LOCK, 0);
         if (card_eject) pop_cmp(K_EJ, 0);
      end

   initial forever begin
      @(negedge clk);
      if (rst && acct_rd) begin
         @(negedge clk);
         acct_password = pw[acct_sel[3:0]];
         acct_balance  = bal[acct_sel[3:0]];
         acct_rd_ack   = 1;
         @(negedge clk);
         acct_rd_ack = 0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst && acct_wr && !hold_wr) begin
         @(negedge clk);
         bal[acct_sel[3:0]] = acct_wr_data;
         acct_wr_ack = 1;
         @(negedge clk);
         acct_wr_ack = 0;
      end
   end

   task automatic settle(input int n = 6);
      repeat (n) @(negedge clk);
   endtask

   task automatic insert(input logic [5:0] n);
      @(negedge clk);
      card_number = n;
      card_in = 1;
      @(negedge clk);
      card_in = 0;
      settle();
   endtask

   task automatic pin(input logic [15:0] p);
      @(negedge clk);
      password_input = p;
      psw_valid = 1;
      @(negedge clk);
      psw_valid = 0;
      settle();
   endtask

   task automatic op(input logic [1:0] c, input logic [19:0] a);
      @(negedge clk);
      op_code = c;
      amount = a;
      op_req = 1;
      @(negedge clk);
      op_req = 0;
      settle();
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(busy), 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         pw[i] = 16'(16'h1000 + i);
         bal[i] = 20'(i * 10);
      end
      pw[3] = 16'h1234; bal[3] = 500;
      pw[2] = 16'h2222; bal[2] = 50;
      pw[5] = 16'h5555; bal[5] = 20'hFFFFF;
      settle(3);
      check("reset_busy", int'(busy), 0);
      check("reset_balance", int'(balance), 0);
      check("reset_err_code", int'(err_code), 0);
      check("reset_acct_sel", int'(acct_sel), 0);
      @(negedge clk);
      rst = 1;
      settle(2);
      op(2'b00, 0);
      pin(16'h1234);
      push(K_RD, 3); insert(3);
      check("load_busy", int'(busy), 1);
      pin(16'h1234);
      check("menu_balance", int'(balance), 500);
      push(K_WR, 400); push(K_DONE, 400); op(2'b01, 100);
      check("wd_balance", int'(balance), 400);
      push(K_DONE, 400); op(2'b00, 0);
      push(K_WR, 500); push(K_DONE, 500); op(2'b10, 100);
      push(K_ERR, 2); op(2'b01, 600);
      check("funds_balance", int'(balance), 500);
      push(K_WR, 0); push(K_DONE, 0); op(2'b01, 500);
      push(K_WR, 500); push(K_DONE, 500); op(2'b10, 500);
      push(K_EJ, 0); op(2'b11, 0);
      check("exit_busy", int'(busy), 0);
      check("exit_balance", int'(balance), 0);
      push(K_RD, 2); insert(2);
      push(K_ERR, 1); pin(16'h0001);
      push(K_ERR, 1); pin(16'h0002);
      check("tries2_busy", int'(busy), 1);
      push(K_ERR, 1); push(K_EJ, 0); pin(16'h0003);
      check("lock_busy", int'(busy), 0);
      push(K_LOCK, 0); push(K_EJ, 0); insert(2);
      check("locked_busy", int'(busy), 0);
      push(K_RD, 5); insert(5);
      pin(16'h5555);
      check("max_balance", int'(balance), 20'hFFFFF);
      push(K_ERR, 3); op(2'b10, 1);
      check("ovf_balance", int'(balance), 20'hFFFFF);
      push(K_EJ, 0);
      settle(900);
      check("pre_timeout_busy", int'(busy), 1);
      wait_idle("timeout_idle", 200);
      check("timeout_balance", int'(balance), 0);
      push(K_ERR, 3); push(K_EJ, 0); insert(12);
      push(K_ERR, 3); push(K_EJ, 0); insert(10);
      check("bad_card_busy", int'(busy), 0);
      push(K_RD, 9); insert(9);
      check("card9_busy", int'(busy), 1);
      pin(16'h1009);
      check("card9_balance", int'(balance), 90);
      push(K_EJ, 0); op(2'b11, 0);
      push(K_RD, 3); insert(3);
      pin(16'h1234);
      hold_wr = 1;
      push(K_WR, 450);
      @(negedge clk); op_code = 2'b01; amount = 50; op_req = 1;
      @(negedge clk); op_req = 0;
      settle(4);
      check("write_busy", int'(busy), 1);
      rst = 0;
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_balance", int'(balance), 0);
      rst = 1;
      hold_wr = 0;
      settle(10);
      check("rst_bal_kept", int'(bal[3]), 500);
      check("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
